// File: rtl/pmem_responder.sv
// Line-granular physical memory responder with programmable response latency.
// Optional sticky protocol checker enabled by defining PMEM_PROTOCOL_CHECK_EN.
module pmem_responder #(
  parameter int LATENCY = 4,
  parameter int LINES   = 4096
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp
`ifdef PMEM_PROTOCOL_CHECK_EN
  ,output logic        protocol_err
`endif
);

  localparam int IDXW = (LINES > 1) ? $clog2(LINES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic            wr;
    logic [IDXW-1:0] idx;
    logic [127:0]    data;
  } req_t;

  state_t       state_q, state_d;
  logic [3:0]   count_q, count_d;
  logic         req_ld, commit;
  req_t         req_in, req_q, cur;
  logic [127:0] mem [LINES];

  // Low nibble of the address selects a byte inside the line and is not needed.
  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, pmem_address[3:0]};

  always_comb begin
    req_in.wr   = !pmem_read;
    req_in.idx  = IDXW'(pmem_address[15:4] % LINES);
    req_in.data = pmem_wdata;
  end

  // With LATENCY == 1 the commit happens on the accept edge, before req_q exists.
  assign cur = (state_q == IDLE) ? req_in : req_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    req_ld  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (pmem_read || pmem_write) begin
        req_ld  = 1'b1;
        count_d = 4'(LATENCY - 1);
        if (LATENCY == 1) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= 4'd0;
      pmem_rdata <= 128'h0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (commit && !cur.wr) pmem_rdata <= mem[cur.idx];
    end
  end

  // Storage is not reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (reset_n && commit && cur.wr) mem[cur.idx] <= cur.data;
  end

  always_ff @(posedge clk) begin
    if (req_ld) req_q <= req_in;
  end

  assign pmem_resp = (state_q == RESP);

`ifdef PMEM_PROTOCOL_CHECK_EN
  logic [15:0] addr_q;
  logic        viol;

  // In BUSY the latched op must still be requested: req_q.wr == pmem_read means it changed.
  assign viol = (pmem_read && pmem_write) ||
                ((state_q == BUSY) &&
                 (!(pmem_read || pmem_write) || (pmem_address != addr_q) ||
                  (req_q.wr == pmem_read)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q       <= 16'h0;
      protocol_err <= 1'b0;
    end else begin
      if (req_ld) addr_q <= pmem_address;
      if (viol) protocol_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: functional paths, latency sweep, reset and protocol cases.
module tb_pmem_responder;
  localparam int LAT = 4;
  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D2 = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [127:0] D3 = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;
  localparam logic [127:0] D4 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] D5 = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
  localparam logic [127:0] DA = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] DB = 128'h8765_4321_8765_4321_8765_4321_8765_4321;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic         rd, wr, resp;
  logic [15:0]  addr;
  logic [127:0] wdata, rdata;
  logic         rd1, wr1, resp1;
  logic [15:0]  addr1;
  logic [127:0] wdata1, rdata1;
  logic         rd15, wr15, resp15;
  logic [15:0]  addr15;
  logic [127:0] wdata15, rdata15;
`ifdef PMEM_PROTOCOL_CHECK_EN
  logic perr, perr1, perr15;
`endif

  pmem_responder #(.LATENCY(LAT), .LINES(4096)) u_dut (
    .clk(clk), .reset_n(reset_n), .pmem_read(rd), .pmem_write(wr),
    .pmem_address(addr), .pmem_wdata(wdata), .pmem_rdata(rdata), .pmem_resp(resp)
`ifdef PMEM_PROTOCOL_CHECK_EN
    ,.protocol_err(perr)
`endif
  );

  pmem_responder #(.LATENCY(1), .LINES(4096)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .pmem_read(rd1), .pmem_write(wr1),
    .pmem_address(addr1), .pmem_wdata(wdata1), .pmem_rdata(rdata1), .pmem_resp(resp1)
`ifdef PMEM_PROTOCOL_CHECK_EN
    ,.protocol_err(perr1)
`endif
  );

  pmem_responder #(.LATENCY(15), .LINES(4096)) u_lat15 (
    .clk(clk), .reset_n(reset_n), .pmem_read(rd15), .pmem_write(wr15),
    .pmem_address(addr15), .pmem_wdata(wdata15), .pmem_rdata(rdata15), .pmem_resp(resp15)
`ifdef PMEM_PROTOCOL_CHECK_EN
    ,.protocol_err(perr15)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the main DUT, request dropped during the resp cycle.
  task automatic xact(input bit r, input bit w, input logic [15:0] a,
                      input logic [127:0] d, output logic [127:0] q);
    rd = r; wr = w; addr = a; wdata = d;
    for (int i = 1; i <= LAT; i++) begin
      step();
      check((i < LAT) ? "resp_early" : "resp_on_time", 128'(resp), 128'(i == LAT));
    end
    q = rdata;
    rd = 1'b0; wr = 1'b0;
    step();
    check("resp_one_cycle", 128'(resp), 128'd0);
  endtask

  logic [127:0] q;

  initial begin
    reset_n = 1'b0;
    rd = 0; wr = 0; addr = 0; wdata = 0;
    rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
    rd15 = 0; wr15 = 0; addr15 = 0; wdata15 = 0;
    step(); step();
    check("rst_resp", 128'(resp), 128'd0);
    check("rst_rdata", rdata, 128'h0);
`ifdef PMEM_PROTOCOL_CHECK_EN
    check("rst_perr", 128'(perr), 128'd0);
`endif
    reset_n = 1'b1;
    step();

    // Write then read same line with different low nibble
    xact(0, 1, 16'h1230, D1, q);
    xact(1, 0, 16'h123E, 128'h0, q);
    check("wr_rd_line", q, D1);

    // Reset during BUSY abandons the write
    xact(0, 1, 16'h0040, DA, q);
    rd = 0; wr = 1; addr = 16'h0040; wdata = DB;
    step(); step();
    reset_n = 1'b0; wr = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rst_no_resp", 128'(resp), 128'd0);
    end
    xact(1, 0, 16'h0040, 128'h0, q);
    check("rst_abandon", q, DA);

    // Back-to-back reads with request held through resp
    rd = 1; wr = 0; addr = 16'h1230;
    for (int c = 1; c <= 2 * LAT + 1; c++) begin
      step();
      check("b2b_resp", 128'(resp), 128'(c == LAT || c == 2 * LAT + 1));
      if (c >= LAT) check("b2b_rdata", rdata, D1);
    end
    rd = 0;
    step();
    check("b2b_resp_end", 128'(resp), 128'd0);

    // Address changed during BUSY: data lands at the accepted address
    xact(0, 1, 16'hFFF0, D3, q);
    rd = 0; wr = 1; addr = 16'h0010; wdata = D2;
    step();
    addr = 16'hFFF0; wdata = D5;
    for (int i = 2; i <= LAT; i++) begin
      step();
      check("achg_resp", 128'(resp), 128'(i == LAT));
    end
    wr = 0;
    step();
`ifdef PMEM_PROTOCOL_CHECK_EN
    check("achg_perr", 128'(perr), 128'd1);
`endif
    xact(1, 0, 16'h0010, 128'h0, q);
    check("achg_dest", q, D2);
    xact(1, 0, 16'hFFF0, 128'h0, q);
    check("achg_other", q, D3);

    // Read and write together: read wins, nothing written
    xact(0, 1, 16'h0020, D4, q);
    xact(1, 1, 16'h0020, D5, q);
    check("both_rdata", q, D4);
    xact(1, 0, 16'h0020, 128'h0, q);
    check("both_nowrite", q, D4);
`ifdef PMEM_PROTOCOL_CHECK_EN
    check("perr_sticky", 128'(perr), 128'd1);
`endif

    // Latency sweep: LATENCY=1 write/read and LATENCY=15 read
    wr1 = 1; addr1 = 16'h0100; wdata1 = D1;
    step();
    check("l1_wr_resp", 128'(resp1), 128'd1);
    wr1 = 0;
    step();
    check("l1_wr_end", 128'(resp1), 128'd0);
    rd1 = 1; rd15 = 1; addr15 = 16'h0200;
    for (int c = 1; c <= 15; c++) begin
      step();
      check("l1_resp", 128'(resp1), 128'(c == 1));
      check("l15_resp", 128'(resp15), 128'(c == 15));
      if (c == 1) begin
        check("l1_rdata", rdata1, D1);
        rd1 = 0;
      end
      if (c == 15) rd15 = 0;
    end
    step();
    check("l15_resp_end", 128'(resp15), 128'd0);

    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_rdata", rdata, 128'h0);
`ifdef PMEM_PROTOCOL_CHECK_EN
    check("post_rst_perr", 128'(perr), 128'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
